// File: rtl/invsqrt_mul_pkg.sv
// -----------------------------------------------------------------------------
// invsqrt_mul_pkg
// Shared defaults and types for the two-requester multiplier arbiter.
//   ASIZE_DEF / BSIZE_DEF : default operand widths (unsigned)
//   MUL_LAT_DEF           : default external multiplier latency in cycles
//   RSP_DEPTH_DEF         : default response buffer depth per requester
//   req_id_t              : requester identifier
//   tag_t                 : one stage of the tag pipe {valid, requester id}
// -----------------------------------------------------------------------------
package invsqrt_mul_pkg;

    localparam int ASIZE_DEF     = 33;
    localparam int BSIZE_DEF     = 47;
    localparam int MUL_LAT_DEF   = 2;
    localparam int RSP_DEPTH_DEF = 2;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/invsqrt_mul_rspfifo.sv
// -----------------------------------------------------------------------------
// invsqrt_mul_rspfifo
// First-word-fall-through FIFO holding products for one requester.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : push wr_data (must never be asserted while full)
//   wr_data    : product to store
//   rd_en      : consumer takes the head entry; ignored when empty
//   rd_data    : head entry, valid whenever empty is low
//   empty      : no entries stored
//   count      : number of entries stored
// -----------------------------------------------------------------------------
module invsqrt_mul_rspfifo #(
    parameter int WIDTH = 80,
    parameter int DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [WIDTH-1:0]                 wr_data,
    input  logic                             rd_en,
    output logic [WIDTH-1:0]                 rd_data,
    output logic                             empty,
    output logic [$clog2(DEPTH+1)-1:0]       count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_rd;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= next_ptr(wr_ptr);
            if (do_rd) rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(wr_en) - CW'(do_rd);
        end
    end

    // NOTE: storage has no reset; an entry is only observable after it has
    // been written, and leaving it unreset lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // The credit scheme upstream must make this impossible.
    assert property (@(posedge clk) disable iff (!rst_n)
                     !(wr_en && (count == CW'(DEPTH))));

endmodule

// File: rtl/invsqrt_mul_arb.sv
// -----------------------------------------------------------------------------
// invsqrt_mul_arb
// Shares one pipelined external multiplier between two requesters. Issues are
// granted round-robin, gated by per-requester credit so that every product
// has a guaranteed slot in that requester's response FIFO.
//   clk, rst_n               : clock, asynchronous active-low reset
//   reqN_valid/ready/a/b     : operand handshake per requester (N = 0, 1)
//   rspN_valid/ready/p       : product handshake per requester
//   mul_ce, mul_a, mul_b     : multiplier enable and operands
//   mul_p                    : multiplier product, MUL_LAT cycles after issue
// -----------------------------------------------------------------------------
module invsqrt_mul_arb
    import invsqrt_mul_pkg::*;
#(
    parameter int ASIZE     = ASIZE_DEF,
    parameter int BSIZE     = BSIZE_DEF,
    parameter int MUL_LAT   = MUL_LAT_DEF,
    parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [ASIZE-1:0]       req0_a,
    input  logic [BSIZE-1:0]       req0_b,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [ASIZE-1:0]       req1_a,
    input  logic [BSIZE-1:0]       req1_b,
    output logic                   rsp0_valid,
    input  logic                   rsp0_ready,
    output logic [ASIZE+BSIZE-1:0] rsp0_p,
    output logic                   rsp1_valid,
    input  logic                   rsp1_ready,
    output logic [ASIZE+BSIZE-1:0] rsp1_p,
    output logic                   mul_ce,
    output logic [ASIZE-1:0]       mul_a,
    output logic [BSIZE-1:0]       mul_b,
    input  logic [ASIZE+BSIZE-1:0] mul_p
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int UW = CW + 1;

    logic [CW-1:0]    inflight0, inflight1;
    logic [CW-1:0]    count0, count1;
    logic             empty0, empty1;
    logic             has_credit0, has_credit1;
    logic             elig0, elig1;
    req_id_t          win;
    req_id_t          rr_ptr;
    logic             issue;
    logic [ASIZE-1:0] issue_a, hold_a;
    logic [BSIZE-1:0] issue_b, hold_b;
    tag_t             tag_q [MUL_LAT];
    tag_t             tag_out;
    logic             wr0, wr1;

    // Credit only looks at registered occupancy, so rspN_ready never reaches
    // reqN_ready combinationally.
    assign has_credit0 = ({1'b0, inflight0} + {1'b0, count0}) < UW'(RSP_DEPTH);
    assign has_credit1 = ({1'b0, inflight1} + {1'b0, count1}) < UW'(RSP_DEPTH);
    assign elig0       = req0_valid && has_credit0;
    assign elig1       = req1_valid && has_credit1;

    // NOTE: every branch of this always_comb assigns win, so no latch forms.
    always_comb begin
        if (elig0 && elig1) win = rr_ptr;
        else if (elig1)     win = REQ1;
        else if (elig0)     win = REQ0;
        else                win = rr_ptr;
    end

    // rst_n gates the handshake and enable directly so nothing is accepted
    // while reset is held, yet the very first edge after release can issue.
    assign req0_ready = rst_n && has_credit0 && (win == REQ0);
    assign req1_ready = rst_n && has_credit1 && (win == REQ1);
    assign issue      = (win == REQ0) ? (req0_valid && req0_ready)
                                      : (req1_valid && req1_ready);
    assign issue_a    = (win == REQ0) ? req0_a : req1_a;
    assign issue_b    = (win == REQ0) ? req0_b : req1_b;
    assign mul_a      = issue ? issue_a : hold_a;
    assign mul_b      = issue ? issue_b : hold_b;
    assign mul_ce     = rst_n;

    assign tag_out = tag_q[MUL_LAT-1];
    assign wr0     = tag_out.valid && (tag_out.id == REQ0);
    assign wr1     = tag_out.valid && (tag_out.id == REQ1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= REQ0;
            hold_a    <= '0;
            hold_b    <= '0;
            inflight0 <= '0;
            inflight1 <= '0;
            for (int i = 0; i < MUL_LAT; i++) tag_q[i] <= '0;
        end else begin
            if (issue) begin
                rr_ptr <= (win == REQ0) ? REQ1 : REQ0;
                hold_a <= issue_a;
                hold_b <= issue_b;
            end
            // Tag pipe mirrors the multiplier stages so the tag leaving the
            // last stage lines up with its product on mul_p.
            tag_q[0] <= '{valid: issue, id: win};
            for (int i = 1; i < MUL_LAT; i++) tag_q[i] <= tag_q[i-1];
            inflight0 <= inflight0 + CW'(issue && (win == REQ0)) - CW'(wr0);
            inflight1 <= inflight1 + CW'(issue && (win == REQ1)) - CW'(wr1);
        end
    end

    invsqrt_mul_rspfifo #(
        .WIDTH (ASIZE + BSIZE),
        .DEPTH (RSP_DEPTH)
    ) u_rsp0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr0),
        .wr_data (mul_p),
        .rd_en   (rsp0_ready),
        .rd_data (rsp0_p),
        .empty   (empty0),
        .count   (count0)
    );

    invsqrt_mul_rspfifo #(
        .WIDTH (ASIZE + BSIZE),
        .DEPTH (RSP_DEPTH)
    ) u_rsp1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr1),
        .wr_data (mul_p),
        .rd_en   (rsp1_ready),
        .rd_data (rsp1_p),
        .empty   (empty1),
        .count   (count1)
    );

    assign rsp0_valid = !empty0;
    assign rsp1_valid = !empty1;

endmodule

// File: tb/tb_invsqrt_mul_arb.sv
// -----------------------------------------------------------------------------
// tb_invsqrt_mul_arb
// Self-checking bench for invsqrt_mul_arb. Inputs change on the falling edge;
// outputs are sampled 1 time unit later. A scoreboard keeps, per requester,
// the queue of products issued and not yet consumed; responses must match the
// queue head and a requester may only be offered ready while it has fewer
// than RSP_DEPTH outstanding products.
// -----------------------------------------------------------------------------
module tb_invsqrt_mul_arb;

    localparam int ASIZE     = 33;
    localparam int BSIZE     = 47;
    localparam int MUL_LAT   = 2;
    localparam int RSP_DEPTH = 2;
    localparam int PW        = ASIZE + BSIZE;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             req0_valid, req1_valid, req0_ready, req1_ready;
    logic [ASIZE-1:0] req0_a, req1_a;
    logic [BSIZE-1:0] req0_b, req1_b;
    logic             rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [PW-1:0]    rsp0_p, rsp1_p;
    logic             mul_ce;
    logic [ASIZE-1:0] mul_a;
    logic [BSIZE-1:0] mul_b;
    logic [PW-1:0]    mul_p;
    logic [PW-1:0]    mpipe [MUL_LAT];

    int n_tests = 0;
    int n_fail  = 0;

    // per-cycle samples
    logic             iss0, iss1, r0v, r1v, mce;
    logic [PW-1:0]    r0p, r1p;
    logic [ASIZE-1:0] ma;
    logic [BSIZE-1:0] mb;
    int               issued_total;

    logic [PW-1:0] q0 [$];
    logic [PW-1:0] q1 [$];

    always #5 clk = ~clk;

    invsqrt_mul_arb #(
        .ASIZE(ASIZE), .BSIZE(BSIZE), .MUL_LAT(MUL_LAT), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_p(rsp0_p),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_p(rsp1_p),
        .mul_ce(mul_ce), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
    );

    // External multiplier: operand and product registers, MUL_LAT stages total.
    initial for (int i = 0; i < MUL_LAT; i++) mpipe[i] = '0;
    always @(posedge clk) begin
        if (mul_ce) begin
            mpipe[0] <= PW'(mul_a) * PW'(mul_b);
            for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mul_p = mpipe[MUL_LAT-1];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic rand_ops();
        req0_a = ASIZE'({$urandom(), $urandom()});
        req0_b = BSIZE'({$urandom(), $urandom()});
        req1_a = ASIZE'({$urandom(), $urandom()});
        req1_b = BSIZE'({$urandom(), $urandom()});
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    endtask

    // One clock: sample at negedge+1, score, then wait for the next negedge.
    task automatic step();
        logic [PW-1:0] e;
        #1;
        iss0 = req0_valid && req0_ready;
        iss1 = req1_valid && req1_ready;
        r0v = rsp0_valid; r1v = rsp1_valid; r0p = rsp0_p; r1p = rsp1_p;
        ma = mul_a; mb = mul_b; mce = mul_ce;
        if (rst_n) begin
            n_tests++;
            if (req0_ready && req1_ready) begin
                n_fail++;
                $display("FAIL single_grant: req0_ready=1 req1_ready=1, required at most one high");
            end
            n_tests++;
            if (req0_ready && q0.size() >= RSP_DEPTH) begin
                n_fail++;
                $display("FAIL credit0: req0_ready=1 with %0d outstanding, required < %0d", q0.size(), RSP_DEPTH);
            end
            n_tests++;
            if (req1_ready && q1.size() >= RSP_DEPTH) begin
                n_fail++;
                $display("FAIL credit1: req1_ready=1 with %0d outstanding, required < %0d", q1.size(), RSP_DEPTH);
            end
            if (r0v && rsp0_ready) begin
                n_tests++;
                if (q0.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp0_spurious: product %0h delivered, required none outstanding", r0p);
                end else begin
                    e = q0.pop_front();
                    if (r0p !== e) begin
                        n_fail++;
                        $display("FAIL rsp0_data: got %0h, required %0h", r0p, e);
                    end
                end
            end
            if (r1v && rsp1_ready) begin
                n_tests++;
                if (q1.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp1_spurious: product %0h delivered, required none outstanding", r1p);
                end else begin
                    e = q1.pop_front();
                    if (r1p !== e) begin
                        n_fail++;
                        $display("FAIL rsp1_data: got %0h, required %0h", r1p, e);
                    end
                end
            end
        end
        if (iss0) begin q0.push_back(PW'(req0_a) * PW'(req0_b)); issued_total++; end
        if (iss1) begin q1.push_back(PW'(req1_a) * PW'(req1_b)); issued_total++; end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 0;
        idle_inputs();
        q0.delete(); q1.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
        @(negedge clk);
        #1;
        n_tests++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: req0_ready=%b req1_ready=%b, required 0 0", req0_ready, req1_ready);
        end
        n_tests++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp_valid: rsp0_valid=%b rsp1_valid=%b, required 0 0", rsp0_valid, rsp1_valid);
        end
        n_tests++;
        if (mul_ce !== 1'b0 || mul_a !== '0 || mul_b !== '0) begin
            n_fail++;
            $display("FAIL reset_mul: mul_ce=%b mul_a=%0h mul_b=%0h, required 0 0 0", mul_ce, mul_a, mul_b);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
    endtask

    task automatic test_single();
        apply_reset();
        rsp0_ready = 1; rsp1_ready = 1;
        req0_valid = 1; req0_a = 33'd3; req0_b = 47'd5;
        step();
        n_tests++;
        if (iss0 !== 1'b1) begin
            n_fail++;
            $display("FAIL single_issue: issue0=%b, required 1", iss0);
        end
        n_tests++;
        if (ma !== 33'd3 || mb !== 47'd5 || mce !== 1'b1) begin
            n_fail++;
            $display("FAIL single_mul_ops: mul_a=%0d mul_b=%0d mul_ce=%b, required 3 5 1", ma, mb, mce);
        end
        req0_valid = 0; req0_a = '0; req0_b = '0;
        for (int k = 1; k <= MUL_LAT + 1; k++) begin
            step();
            n_tests++;
            if (r0v !== (k == MUL_LAT + 1)) begin
                n_fail++;
                $display("FAIL single_latency: cycle %0d after issue rsp0_valid=%b, required %b", k, r0v, (k == MUL_LAT + 1));
            end
            n_tests++;
            if (r1v !== 1'b0) begin
                n_fail++;
                $display("FAIL single_rsp1: rsp1_valid=%b, required 0", r1v);
            end
            if (k == MUL_LAT + 1) begin
                n_tests++;
                if (r0p !== 80'd15) begin
                    n_fail++;
                    $display("FAIL single_product: rsp0_p=%0d, required 15", r0p);
                end
            end
        end
        n_tests++;
        if (ma !== 33'd3 || mb !== 47'd5) begin
            n_fail++;
            $display("FAIL mul_hold: idle mul_a=%0d mul_b=%0d, required 3 5", ma, mb);
        end
    endtask

    task automatic test_alternate();
        logic exp0;
        apply_reset();
        rsp0_ready = 1; rsp1_ready = 1;
        for (int i = 0; i < 8; i++) begin
            req0_valid = 1; req1_valid = 1;
            rand_ops();
            step();
            exp0 = (i % 2 == 0);
            n_tests++;
            if (iss0 !== exp0 || iss1 !== !exp0) begin
                n_fail++;
                $display("FAIL grant_order: cycle %0d issue0=%b issue1=%b, required %b %b", i, iss0, iss1, exp0, !exp0);
            end
        end
        req0_valid = 0; req1_valid = 0;
        repeat (6) step();
        n_tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL alt_drain: outstanding %0d/%0d, required 0/0", q0.size(), q1.size());
        end
    endtask

    task automatic test_backpressure();
        int c0, c1;
        apply_reset();
        c0 = 0; c1 = 0;
        rsp0_ready = 0; rsp1_ready = 1;
        for (int i = 0; i < 20; i++) begin
            req0_valid = 1; req1_valid = 1;
            rand_ops();
            step();
            c0 += int'(iss0);
            c1 += int'(iss1);
        end
        n_tests++;
        if (c0 != RSP_DEPTH) begin
            n_fail++;
            $display("FAIL bp_req0_issues: %0d issues while stalled, required %0d", c0, RSP_DEPTH);
        end
        n_tests++;
        if (c1 < 6) begin
            n_fail++;
            $display("FAIL bp_req1_progress: %0d issues in 20 cycles, required >= 6", c1);
        end
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1;
        repeat (6) step();
        n_tests++;
        if (q0.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: %0d products left for req0, required 0", q0.size());
        end
        c0 = 0;
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1;
            rand_ops();
            step();
            c0 += int'(iss0);
        end
        req0_valid = 0;
        repeat (6) step();
        n_tests++;
        if (c0 < 1) begin
            n_fail++;
            $display("FAIL bp_resume: req0 issued %0d after drain, required >= 1", c0);
        end
    endtask

    task automatic test_max_operands();
        logic [PW-1:0] exp;
        logic          got;
        apply_reset();
        rsp0_ready = 1; rsp1_ready = 1;
        req0_valid = 1; req0_a = '1; req0_b = '1;
        exp = ((80'd1 << 33) - 80'd1) * ((80'd1 << 47) - 80'd1);
        step();
        req0_valid = 0;
        got = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (r0v && !got) begin
                got = 1;
                n_tests++;
                if (r0p !== exp) begin
                    n_fail++;
                    $display("FAIL max_product: rsp0_p=%0h, required %0h", r0p, exp);
                end
            end
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL max_timeout: rsp0_valid=0 after 6 cycles, required 1");
        end
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        rsp0_ready = 1; rsp1_ready = 1;
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1; req1_valid = 1;
            rand_ops();
            step();
        end
        idle_inputs();
        rst_n = 0;
        q0.delete(); q1.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        rsp0_ready = 1; rsp1_ready = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_tests++;
            if (r0v || r1v) begin
                n_fail++;
                $display("FAIL midreset_flush: rsp0_valid=%b rsp1_valid=%b at cycle %0d, required 0 0", r0v, r1v, i);
            end
        end
        req0_valid = 1; req1_valid = 1;
        rand_ops();
        step();
        n_tests++;
        if (iss0 !== 1'b1 || iss1 !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_first_grant: issue0=%b issue1=%b, required 1 0", iss0, iss1);
        end
        req0_valid = 0; req1_valid = 0;
        repeat (6) step();
        n_tests++;
        if (q0.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_next_op: %0d products not returned, required 0", q0.size());
        end
    endtask

    task automatic test_random();
        apply_reset();
        issued_total = 0;
        for (int i = 0; i < 10000; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            rand_ops();
            step();
        end
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        repeat (10) step();
        n_tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL random_loss: outstanding %0d/%0d after drain, required 0/0", q0.size(), q1.size());
        end
        n_tests++;
        if (issued_total < 3000) begin
            n_fail++;
            $display("FAIL random_throughput: %0d issues in 10000 cycles, required >= 3000", issued_total);
        end
    endtask

    initial begin
        idle_inputs();
        issued_total = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_max_operands();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
